// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_DATA   = 1'b1;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the requester not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == REQ_DATA) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates ifetch/data requesters onto one req/gnt/rvalid memory port.
// Optional response timeout is enabled with MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                                 clk,
  input  logic                                 rst_ni,
  input  logic [1:0]                           req_valid_i,
  output logic [1:0]                           req_ready_o,
  input  logic [2*ADDR_WIDTH-1:0]              req_addr_i,
  input  logic [1:0]                           req_we_i,
  input  logic [2*DATA_WIDTH-1:0]              req_wdata_i,
  input  logic [2*strb_width(DATA_WIDTH)-1:0]  req_wstrb_i,
  output logic [1:0]                           rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  output logic [strb_width(DATA_WIDTH)-1:0]    mem_wstrb_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  output logic                                 err_o
);

  localparam int unsigned SW = strb_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  mem_req_q, mem_req_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            grant;
  logic                  sel;
  logic                  handshake;
  logic                  timeout_c;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Accept is combinational so a request can be taken in the cycle it appears.
  assign req_ready_o = (state_q == IDLE) ? grant : 2'b00;
  assign handshake   = |(req_valid_i & req_ready_o);
  assign sel         = grant[REQ_DATA];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_c = (state_q == WAIT_RSP) && !mem_rvalid_i &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT);
  assign timeout_c      = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    err_d        = err_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    // A response with no transaction outstanding is a protocol error.
    if (mem_rvalid_i && (state_q != WAIT_RSP)) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          owner_d      = sel;
          last_grant_d = sel;
          we_d         = sel ? req_we_i[1] : req_we_i[0];
          addr_d       = sel ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
          wdata_d      = sel ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
          wstrb_d      = sel ? req_wstrb_i[2*SW-1:SW] : req_wstrb_i[SW-1:0];
          state_d      = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (mem_gnt_i) begin
          state_d = WAIT_RSP;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_RSP: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = CNT_W'(cnt_q + 1'b1);
`endif
        if (mem_rvalid_i) begin
          rsp_rdata_d = mem_rdata_i;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d     = IDLE;
        end else if (timeout_c) begin
          rsp_rdata_d = '0;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d == WAIT_GNT);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DATA;
      owner_q      <= REQ_IFETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      mem_req_q    <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      mem_req_q    <= mem_req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign err_o       = err_q;

endmodule
